// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions. Instruction field positions (also
//               used by the decoder), branch-offset width, fetch-unit state
//               encoding, and a helper that extracts the split branch offset.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction word layout: opcode [15:9], rd [8:6], rsA [5:3], rsB [2:0]
    localparam int c_INSTR_W  = 16;
    localparam int c_OPC_MSB  = 15;
    localparam int c_OPC_LSB  = 9;
    localparam int c_RD_MSB   = 8;
    localparam int c_RD_LSB   = 6;
    localparam int c_RSA_MSB  = 5;
    localparam int c_RSA_LSB  = 3;
    localparam int c_RSB_MSB  = 2;
    localparam int c_RSB_LSB  = 0;

    // Branch offset is {rd, rsB}: 6-bit two's complement, -32..+31
    localparam int c_BR_OFS_W = 6;

    // Fetch-unit states
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_ISSUE = 2'd2
    } fetch_state_e;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;

    // Concatenate the rd and rsB fields into the raw branch offset.
    function automatic logic [c_BR_OFS_W-1:0] branch_offset(
        input logic [c_INSTR_W-1:0] instr
    );
        return {instr[c_RD_MSB:c_RD_LSB], instr[c_RSB_MSB:c_RSB_LSB]};
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC calculation for the fetch unit.
//               Sequential (pc+1), absolute jump (jump_target) or
//               conditional PC-relative branch on Z or N. All arithmetic
//               wraps modulo 2^AW.
// Ports       : pc          - current program counter
//               instr       - instruction being retired (offset fields)
//               PL, JB, BC  - decoder controls (load / jump-vs-branch / cond)
//               Z, N        - datapath flags for rsA
//               jump_target - absolute jump address
//               next_pc     - resulting program counter
// Revision    : 1.0 - initial release
// ============================================================================
import cpu_pkg::*;

module pc_next #(
    parameter int AW = 8
) (
    input  logic [AW-1:0]        pc,
    input  logic [c_INSTR_W-1:0] instr,
    input  logic                 PL,
    input  logic                 JB,
    input  logic                 BC,
    input  logic                 Z,
    input  logic                 N,
    input  logic [AW-1:0]        jump_target,
    output logic [AW-1:0]        next_pc
);

    logic [c_BR_OFS_W-1:0] w_ofs;
    logic [31:0]           w_ofs_sext;
    logic [AW-1:0]         w_seq_pc;
    logic [AW-1:0]         w_br_pc;
    logic                  w_taken;

    // Opcode and rsA do not influence the next PC.
    logic                  w_unused_fields;
    assign w_unused_fields = ^{instr[c_OPC_MSB:c_OPC_LSB], instr[c_RSA_MSB:c_RSA_LSB]};

    assign w_ofs      = branch_offset(instr);
    // Sign-extend to 32 bits, then keep AW bits: adding the truncated
    // two's-complement value gives the correct result modulo 2^AW.
    assign w_ofs_sext = {{(32-c_BR_OFS_W){w_ofs[c_BR_OFS_W-1]}}, w_ofs};
    assign w_seq_pc   = pc + AW'(1);
    assign w_br_pc    = pc + w_ofs_sext[AW-1:0];
    assign w_taken    = BC ? N : Z;

    always_comb begin
        next_pc = w_seq_pc;
        if (PL) begin
            if (JB) begin
                next_pc = jump_target;
            end else if (w_taken) begin
                next_pc = w_br_pc;
            end
        end
    end

endmodule : pc_next
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Non-pipelined instruction fetch unit. Owns the PC and the
//               instruction register, reads one 16-bit word per instruction
//               from instruction memory and hands it to the decoder with a
//               valid/ready handshake. The next PC is computed when the
//               decoder accepts the instruction.
// Ports       : clk, rst_n              - clock, async active-low reset
//               run                     - leave IDLE and start fetching
//               imem_req/addr/ack/rdata - instruction memory read port
//               instr, instr_valid      - instruction register to decoder
//               instr_ready             - decoder/datapath consumes instr
//               PL, JB, BC, Z, N        - next-PC controls and flags
//               jump_target             - absolute jump address
//               pc                      - current program counter
// Revision    : 1.0 - initial release
// ============================================================================
import cpu_pkg::*;

module instr_fetch #(
    parameter int          AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic                 imem_req,
    output logic [AW-1:0]        imem_addr,
    input  logic                 imem_ack,
    input  logic [c_INSTR_W-1:0] imem_rdata,
    output logic [c_INSTR_W-1:0] instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 PL,
    input  logic                 JB,
    input  logic                 BC,
    input  logic                 Z,
    input  logic                 N,
    input  logic [AW-1:0]        jump_target,
    output logic [AW-1:0]        pc
);

    logic [1:0]           r_state;
    logic [AW-1:0]        r_pc;
    logic [c_INSTR_W-1:0] r_instr;
    logic [AW-1:0]        w_next_pc;

    pc_next #(
        .AW          (AW)
    ) u_pc_next (
        .pc          (r_pc),
        .instr       (r_instr),
        .PL          (PL),
        .JB          (JB),
        .BC          (BC),
        .Z           (Z),
        .N           (N),
        .jump_target (jump_target),
        .next_pc     (w_next_pc)
    );

    // Once running, the unit alternates FETCH/ISSUE forever; only reset
    // brings it back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (run) begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (instr_ready) begin
                        r_pc    <= w_next_pc;
                        r_state <= c_ST_FETCH;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are registers or pure state decodes, so neither
    // instr_ready nor imem_ack reaches an output combinationally. Because
    // reset is asynchronous, imem_req drops as soon as rst_n asserts.
    assign imem_req    = (r_state == c_ST_FETCH);
    assign instr_valid = (r_state == c_ST_ISSUE);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. The bench plays both
//               instruction memory and decoder, and tracks the expected PC
//               with an arithmetic model of the next-PC rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int          AW       = 8;
    localparam logic [7:0]  RESET_PC = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        PL, JB, BC, Z, N;
    logic [7:0]  jump_target;
    logic [7:0]  pc;

    int          n_vec;
    int          n_err;
    logic [7:0]  pc_m;

    localparam logic [15:0] c_BR_M4 = 16'b110_0000_111_101_100;

    instr_fetch #(
        .AW          (AW),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PL          (PL),
        .JB          (JB),
        .BC          (BC),
        .Z           (Z),
        .N           (N),
        .jump_target (jump_target),
        .pc          (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC rule written as plain integer arithmetic.
    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [15:0] w,
                                              input logic pl, input logic jb, input logic bc,
                                              input logic z, input logic n, input logic [7:0] jt);
        int off;
        int res;
        if (!pl) return 8'((int'(cur) + 1) % 256);
        if (jb) return jt;
        if ((bc && n) || (!bc && z)) begin
            off = int'({w[8:6], w[2:0]});
            if (off >= 32) off = off - 64;
            res = (int'(cur) + off + 256) % 256;
            return 8'(res);
        end
        return 8'((int'(cur) + 1) % 256);
    endfunction

    // One full instruction: FETCH with ad wait cycles, then ISSUE with rd
    // not-ready cycles, then acceptance with the given controls.
    task automatic do_instr(input int ad, input int rd, input logic pl, input logic jb,
                            input logic bc, input logic z, input logic n,
                            input logic [7:0] jt, input logic [15:0] word);
        logic [7:0] exp_pc;
        check("req_fetch", imem_req, 1);
        check("addr_fetch", imem_addr, pc_m);
        check("vld_fetch", instr_valid, 0);
        for (int i = 0; i < ad; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            tick();
            check("req_hold", imem_req, 1);
            check("addr_hold", imem_addr, pc_m);
            check("vld_wait", instr_valid, 0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        check("vld_issue", instr_valid, 1);
        check("req_issue", imem_req, 0);
        check("instr", instr, word);
        check("pc_issue", pc, pc_m);
        for (int i = 0; i < rd; i++) begin
            instr_ready = 1'b0;
            {PL, JB, BC, Z, N} = 5'($urandom);
            jump_target = 8'($urandom);
            imem_ack    = 1'($urandom);
            imem_rdata  = 16'($urandom);
            tick();
            check("instr_stable", instr, word);
            check("vld_stall", instr_valid, 1);
            check("pc_stall", pc, pc_m);
        end
        imem_ack    = 1'($urandom);
        imem_rdata  = 16'($urandom);
        instr_ready = 1'b1;
        {PL, JB, BC, Z, N} = {pl, jb, bc, z, n};
        jump_target = jt;
        exp_pc = model_next(pc_m, word, pl, jb, bc, z, n, jt);
        tick();
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        pc_m        = exp_pc;
        check("pc_next", pc, pc_m);
        check("vld_drop", instr_valid, 0);
        check("req_next", imem_req, 1);
        check("instr_keep", instr, word);
    endtask

    task automatic seq(input int ad, input int rd);
        do_instr(ad, rd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'($urandom));
    endtask

    task automatic jmp(input logic [7:0] tgt);
        do_instr(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tgt, 16'($urandom));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        run = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        {PL, JB, BC, Z, N} = '0;
        jump_target = '0;
        pc_m = RESET_PC;

        tick();
        tick();
        check("rst_req", imem_req, 0);
        check("rst_vld", instr_valid, 0);
        check("rst_pc", pc, RESET_PC);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_instr", instr, 16'h0000);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_req", imem_req, 0);
            check("idle_vld", instr_valid, 0);
        end
        imem_ack = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;

        // Back-to-back, zero-wait: addresses 0,1,2,3
        for (int i = 0; i < 4; i++) seq(0, 0);
        // Waits on both sides at pc=5
        jmp(8'd5);
        seq(3, 2);
        check("pc_after_wait", pc, 8'd6);
        // Branch -4 at pc=10: Z taken, Z not taken, N taken
        jmp(8'd10);
        do_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, c_BR_M4);
        check("br_z_taken", imem_addr, 8'd6);
        jmp(8'd10);
        do_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, c_BR_M4);
        check("br_z_not", imem_addr, 8'd11);
        jmp(8'd10);
        do_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, c_BR_M4);
        check("br_n_taken", imem_addr, 8'd6);
        // Jump at pc=20 to 0x80
        jmp(8'd20);
        jmp(8'h80);
        check("jmp_80", imem_addr, 8'h80);
        // Backward branch wrapping below zero
        jmp(8'd2);
        do_instr(1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, c_BR_M4);
        check("br_wrap", imem_addr, 8'hFE);
        // Sequential wrap from top of address space
        jmp(8'hFF);
        seq(0, 1);
        check("seq_wrap", imem_addr, 8'h00);
        // Zero-offset taken branch refetches itself
        jmp(8'h40);
        do_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'hFE38);
        check("self_loop", imem_addr, 8'h40);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 8'($urandom), 16'($urandom));
        end

        // Reset while waiting for an ack
        imem_ack = 1'b0;
        tick();
        check("pre_rst_req", imem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_vld", instr_valid, 0);
        check("arst_pc", pc, RESET_PC);
        check("arst_instr", instr, 16'h0000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_idle", imem_req, 0);
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        pc_m = RESET_PC;
        check("restart_addr", imem_addr, RESET_PC);
        seq(0, 0);
        seq(2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
